// File: rtl/nand4_stim_pkg.sv
// Shared types and the arc vector table for the NAND4 characterisation driver.
// Even indices pull one input low (QN=1); odd indices drive all-ones (QN=0).
package nand4_stim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    localparam int NUM_VEC = 8;
    localparam int IDX_W   = 3;

    typedef struct packed {
        logic [3:0] vec;
        logic       exp_qn;
    } arc_vec_t;

    // Vector bit 0 is IN1; even idx 2k clears input k+1 so each arc toggles once.
    function automatic arc_vec_t arc_lookup(input logic [IDX_W-1:0] idx);
        arc_vec_t r;
        if (idx[0]) begin
            r.vec    = 4'b1111;
            r.exp_qn = 1'b0;
        end else begin
            r.vec    = ~(4'b0001 << idx[2:1]);
            r.exp_qn = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nand4_arc_vec.sv
// Combinational index -> {cell input vector, expected QN} lookup.
module nand4_arc_vec
    import nand4_stim_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [3:0]       vec,
    output logic             exp_qn
);

    arc_vec_t entry;

    assign entry  = arc_lookup(idx);
    assign vec    = entry.vec;
    assign exp_qn = entry.exp_qn;

endmodule

// File: rtl/nand4_arc_stim.sv
// Stimulus-and-check driver for a NAND4 cell: sweeps every input->QN arc,
// counts QN toggles and sampled mismatches, all outputs registered.
module nand4_arc_stim
    import nand4_stim_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int REPEAT      = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             abort,
    input  logic             qn_obs,
    output logic             in1,
    output logic             in2,
    output logic             in3,
    output logic             in4,
    output logic             busy,
    output logic             done,
    output logic [2:0]       vec_idx,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SWEEP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(REPEAT - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_VEC - 1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx_nx;
    logic [HOLD_W-1:0]  hold, hold_nx;
    logic [SWEEP_W-1:0] sweep, sweep_nx;
    logic               prev_qn, prev_nx;
    logic [CNT_W-1:0]   tog_nx, err_nx;
    logic [3:0]         drive, nxt_vec;
    logic               exp_qn, nxt_exp;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Looked up on the next index so drive and exp_qn register alongside vec_idx.
    nand4_arc_vec u_vec (
        .idx    (idx_nx),
        .vec    (nxt_vec),
        .exp_qn (nxt_exp)
    );

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        idx_nx   = vec_idx;
        hold_nx  = hold;
        sweep_nx = sweep;
        prev_nx  = prev_qn;
        tog_nx   = toggle_cnt;
        err_nx   = err_cnt;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = RUN;
                    idx_nx   = '0;
                    hold_nx  = '0;
                    sweep_nx = '0;
                    prev_nx  = qn_obs;
                    tog_nx   = '0;
                    err_nx   = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    prev_nx = qn_obs;
                    if (qn_obs != prev_qn) tog_nx = sat_inc(toggle_cnt);
                    if (hold == HOLD_LAST) begin
                        if (qn_obs != exp_qn) err_nx = sat_inc(err_cnt);
                        hold_nx = '0;
                        idx_nx  = vec_idx + IDX_W'(1);
                        if (vec_idx == IDX_LAST) begin
                            if (sweep == SWEEP_LAST) state_nx = FINISH;
                            else                     sweep_nx = sweep + SWEEP_W'(1);
                        end
                    end else begin
                        hold_nx = hold + HOLD_W'(1);
                    end
                end
            end
            FINISH: begin
                // The closing edge back to 0000 completes the last sweep's 8th toggle.
                state_nx = IDLE;
                prev_nx  = qn_obs;
                if (qn_obs != prev_qn) tog_nx = sat_inc(toggle_cnt);
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            vec_idx    <= '0;
            hold       <= '0;
            sweep      <= '0;
            prev_qn    <= 1'b0;
            toggle_cnt <= '0;
            err_cnt    <= '0;
            drive      <= 4'b0000;
            exp_qn     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            vec_idx    <= idx_nx;
            hold       <= hold_nx;
            sweep      <= sweep_nx;
            prev_qn    <= prev_nx;
            toggle_cnt <= tog_nx;
            err_cnt    <= err_nx;
            drive      <= (state_nx == RUN) ? nxt_vec : 4'b0000;
            exp_qn     <= nxt_exp;
            busy       <= (state_nx == RUN);
            done       <= (state_nx == FINISH);
        end
    end

    assign in1 = drive[0];
    assign in2 = drive[1];
    assign in3 = drive[2];
    assign in4 = drive[3];

endmodule

// File: tb/tb_nand4_arc_stim.sv
// Directed bench for nand4_arc_stim: a NAND4 cell model (optionally stuck at 1)
// closes the loop; a second CNT_W=3 instance exercises toggle saturation.
module tb_nand4_arc_stim;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstb, start, abort, start_b, stuck;
    logic        qn_obs, b_qn;
    logic        in1, in2, in3, in4, busy, done;
    logic [2:0]  vec_idx;
    logic [15:0] toggle_cnt, err_cnt;
    logic        b_in1, b_in2, b_in3, b_in4, b_busy, b_done;
    logic [2:0]  b_vec_idx, b_toggle, b_err;

    int n_checks = 0;
    int n_errs   = 0;

    logic [3:0] tbl [8];
    int         done_k, seq_bad;
    logic       busy_k1, busy_k66, done_k66;
    logic [3:0] fin_in;
    logic       done_seen;

    assign qn_obs = stuck ? 1'b1 : ~(in1 & in2 & in3 & in4);
    assign b_qn   = ~(b_in1 & b_in2 & b_in3 & b_in4);

    nand4_arc_stim #(.HOLD_CYCLES(4), .REPEAT(2), .CNT_W(16)) dut (
        .clk(clk), .rstb(rstb), .start(start), .abort(abort), .qn_obs(qn_obs),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4), .busy(busy), .done(done),
        .vec_idx(vec_idx), .toggle_cnt(toggle_cnt), .err_cnt(err_cnt)
    );

    nand4_arc_stim #(.HOLD_CYCLES(4), .REPEAT(2), .CNT_W(3)) dut_sat (
        .clk(clk), .rstb(rstb), .start(start_b), .abort(1'b0), .qn_obs(b_qn),
        .in1(b_in1), .in2(b_in2), .in3(b_in3), .in4(b_in4), .busy(b_busy), .done(b_done),
        .vec_idx(b_vec_idx), .toggle_cnt(b_toggle), .err_cnt(b_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Pulses start, then watches 80 cycles; k counts cycles after the sampling edge.
    task automatic run_once(input bit with_b, input int re1, input int re2);
        done_k   = -1;
        seq_bad  = 0;
        busy_k1  = 1'b0;
        busy_k66 = 1'b1;
        done_k66 = 1'b1;
        fin_in   = 4'hf;
        @(negedge clk);
        start   = 1'b1;
        start_b = with_b;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            start   = 1'b0;
            start_b = 1'b0;
            if (k == 1) busy_k1 = busy;
            if (k <= 64 && ({in4, in3, in2, in1} !== tbl[((k - 1) / 4) % 8] || busy !== 1'b1))
                seq_bad++;
            if (done === 1'b1 && done_k < 0) begin
                done_k = k;
                fin_in = {in4, in3, in2, in1};
            end
            if (k == 66) begin
                busy_k66 = busy;
                done_k66 = done;
            end
            if (k == re1 || k == re2) start = 1'b1;
        end
    endtask

    initial begin
        tbl[0] = 4'b1110; tbl[1] = 4'b1111; tbl[2] = 4'b1101; tbl[3] = 4'b1111;
        tbl[4] = 4'b1011; tbl[5] = 4'b1111; tbl[6] = 4'b0111; tbl[7] = 4'b1111;
        rstb = 1'b0; start = 1'b0; abort = 1'b0; start_b = 1'b0; stuck = 1'b0;

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", vec_idx, 0);
        check("rst_in", {in4, in3, in2, in1}, 0);
        check("rst_tog", toggle_cnt, 0);
        check("rst_err", err_cnt, 0);
        check("rst_b_busy", b_busy, 0);
        check("rst_b_tog", b_toggle, 0);
        #10 rstb = 1'b1;

        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_in", {in4, in3, in2, in1}, 0);

        // Golden run on both instances.
        run_once(1'b1, 0, 0);
        check("gold_busy_t1", busy_k1, 1);
        check("gold_done_at", done_k, 65);
        check("gold_in_seq_bad", seq_bad, 0);
        check("gold_fin_in", fin_in, 0);
        check("gold_done_width", done_k66, 0);
        check("gold_busy_after", busy_k66, 0);
        check("gold_tog", toggle_cnt, 16);
        check("gold_err", err_cnt, 0);
        check("sat_tog", b_toggle, 7);
        check("sat_err", b_err, 0);

        // START re-pulsed mid-run and during FINISH: no effect.
        run_once(1'b0, 20, 65);
        check("restart_done_at", done_k, 65);
        check("restart_in_seq_bad", seq_bad, 0);
        check("restart_busy_after", busy_k66, 0);
        check("restart_tog", toggle_cnt, 16);
        check("restart_err", err_cnt, 0);

        // QN stuck at 1: every odd (all-ones) vector mismatches.
        stuck = 1'b1;
        run_once(1'b0, 0, 0);
        check("stuck_done_at", done_k, 65);
        check("stuck_err", err_cnt, 8);
        check("stuck_tog", toggle_cnt, 0);
        stuck = 1'b0;

        // Abort at VEC_IDX=3, hold=1 of sweep 0 (cycle 14).
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        check("abort_pos_idx", vec_idx, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        done_seen = done;
        check("abort_busy", busy, 0);
        check("abort_in", {in4, in3, in2, in1}, 0);
        check("abort_tog", toggle_cnt, 3);
        check("abort_err", err_cnt, 0);
        repeat (5) begin
            @(negedge clk);
            done_seen = done_seen | done;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_tog_frozen", toggle_cnt, 3);

        // Async reset mid-hold of VEC_IDX=5.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (21) @(negedge clk);
        check("rst_pos_idx", vec_idx, 5);
        check("rst_pos_tog", toggle_cnt, 5);
        #1 rstb = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_in", {in4, in3, in2, in1}, 0);
        check("arst_idx", vec_idx, 0);
        check("arst_tog", toggle_cnt, 0);
        check("arst_err", err_cnt, 0);
        #1 rstb = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_in", {in4, in3, in2, in1}, 0);
        check("post_rst_tog", toggle_cnt, 0);

        // START together with ABORT in IDLE is ignored.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", busy, 0);
        @(negedge clk);
        check("start_abort_in", {in4, in3, in2, in1}, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
